spiflash_reader: RTL and testbench

SPIFLASH_READER -- requirements
Module: spiflash_reader

---
 rtl/spiflash_reader.sv | 193 +++++++++++++++++++
 tb/tb_spiflash_reader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_reader.sv
// spiflash_reader
// Reads a run of bytes from a serial NOR flash over SPI mode 0.
// A request gives a 24-bit start address and a 16-bit byte count. Every
// received byte goes out on a valid/ready style output port.
//
// Build option:
//   SPIFLASH_FASTREAD_EN - when defined, the block uses FAST READ (0x0B) and
//                          sends 8 dummy clocks. When undefined, it uses
//                          plain READ (0x03) and has no dummy phase at all.
//
// Parameter:
//   CLK_DIV     - clk cycles per SCK level (1..255). The SCK period is
//                 2*CLK_DIV clk cycles.
//
// Ports:
//   clk, rst_n  - system clock; synchronous active-low reset
//   start       - read request. It is only sampled while idle.
//   addr, len   - start address and byte count, captured with start
//   busy        - a transaction is in progress
//   data        - received byte
//   data_valid  - data holds a byte that has not been consumed yet
//   data_ready  - the consumer takes data when this and data_valid are high
//   done        - one-cycle pulse when a transaction ends
//   spi_ss, spi_sck, spi_mosi, spi_miso - SPI bus (chip select is active low)
module spiflash_reader #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic [7:0]  data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        done,
  output logic        spi_ss,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef SPIFLASH_FASTREAD_EN
  localparam logic [7:0] OPCODE = 8'h0B;
`else
  localparam logic [7:0] OPCODE = 8'h03;
`endif

  localparam logic [8:0] HALF_LAST  = 9'(CLK_DIV - 1);
  localparam logic [8:0] DESEL_LAST = 9'(2 * CLK_DIV - 1);

`ifdef SPIFLASH_FASTREAD_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DESEL} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DESEL} state_t;
`endif

  state_t      state_q, state_d;
  logic [8:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [4:0]  bit_last;
  logic [31:0] tx_sr;
  logic [6:0]  rx_sr;
  logic [15:0] remaining;
  logic        stalled;
  logic        tick;
  logic        stall_enter;
  logic        do_fall;
  logic        end_of_phase;

  // This process decodes the SCK timing strobes and the next state.
  // A stall holds SCK low at a byte boundary. It happens only when the
  // previous byte has not been consumed by the time the first rising edge
  // of the next byte is due.
  always_comb begin
    state_d      = state_q;
    bit_last     = (state_q == ADDR) ? 5'd23 : 5'd7;
    tick         = (div_cnt == HALF_LAST) && !stalled;
    stall_enter  = (state_q == DATA) && tick && !spi_sck &&
                   (bit_cnt == 5'd0) && data_valid;
    do_fall      = tick && spi_sck;
    end_of_phase = do_fall && (bit_cnt == bit_last);

    case (state_q)
      IDLE:  if (start && (len != 16'd0)) state_d = CMD;
      CMD:   if (end_of_phase) state_d = ADDR;
`ifdef SPIFLASH_FASTREAD_EN
      ADDR:  if (end_of_phase) state_d = DUMMY;
      DUMMY: if (end_of_phase) state_d = DATA;
`else
      ADDR:  if (end_of_phase) state_d = DATA;
`endif
      DATA:  if (end_of_phase && (remaining == 16'd0)) state_d = DESEL;
      DESEL: if (div_cnt == DESEL_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // This process holds the state register and the SPI datapath.
  // MOSI changes only on falling SCK edges. MISO is sampled on the clk
  // edge that drives SCK high. The remaining-byte count is decremented on
  // the 8th rising edge, so the falling edge that follows can tell whether
  // that byte was the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cnt    <= 9'd0;
      bit_cnt    <= 5'd0;
      tx_sr      <= 32'd0;
      rx_sr      <= 7'd0;
      remaining  <= 16'd0;
      stalled    <= 1'b0;
      busy       <= 1'b0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      done       <= 1'b0;
      spi_ss     <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state_q)
        IDLE: begin
          div_cnt <= 9'd0;
          bit_cnt <= 5'd0;
          stalled <= 1'b0;
          if (start) begin
            if (len == 16'd0) begin
              done <= 1'b1;
            end else begin
              busy      <= 1'b1;
              spi_ss    <= 1'b0;
              spi_mosi  <= OPCODE[7];
              tx_sr     <= {OPCODE[6:0], addr, 1'b0};
              remaining <= len;
            end
          end
        end

        DESEL: begin
          if (div_cnt == DESEL_LAST) begin
            div_cnt <= 9'd0;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end

        default: begin
          // While stalled, the low-phase counter stays at zero. After the
          // consumer takes the byte, the low phase restarts at full length.
          if (stalled) begin
            div_cnt <= 9'd0;
            if (!data_valid) stalled <= 1'b0;
          end else if (stall_enter) begin
            stalled <= 1'b1;
            div_cnt <= 9'd0;
          end else if (tick) begin
            div_cnt <= 9'd0;
            spi_sck <= ~spi_sck;
            if (!spi_sck) begin
              if (state_q == DATA) begin
                rx_sr <= {rx_sr[5:0], spi_miso};
                if (bit_cnt == 5'd7) begin
                  data       <= {rx_sr, spi_miso};
                  data_valid <= 1'b1;
                  remaining  <= remaining - 16'd1;
                end
              end
            end else begin
              bit_cnt <= end_of_phase ? 5'd0 : bit_cnt + 5'd1;
              if ((state_q == CMD) || (state_q == ADDR)) begin
                spi_mosi <= tx_sr[31];
                tx_sr    <= {tx_sr[30:0], 1'b0};
              end else begin
                spi_mosi <= 1'b0;
              end
              if (state_d == DESEL) spi_ss <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spiflash_reader.sv
// tb_spiflash_reader
// Self-checking bench for spiflash_reader. A behavioural flash model
// decodes the command and address from MOSI and serves bytes from a
// memory image. When a request is issued, the stimulus side queues the
// expected bytes and transaction records. A monitor running on the
// falling clk edge checks SCK timing, the MOSI contents, the received
// bytes and each done pulse against those queues.
// It follows the SPIFLASH_FASTREAD_EN build option of the design.
module tb_spiflash_reader;

  localparam int CLK_DIV = 4;
`ifdef SPIFLASH_FASTREAD_EN
  localparam logic [7:0] OPC = 8'h0B;
  localparam int         HDR = 40;
`else
  localparam logic [7:0] OPC = 8'h03;
  localparam int         HDR = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] addr;
  logic [15:0] len;
  logic        busy;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_ready;
  logic        done;
  logic        spi_ss;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  spiflash_reader #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .len(len),
    .busy(busy), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .done(done), .spi_ss(spi_ss),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [15:0] l;
  } txn_t;

  logic [7:0]  fmem [1024];
  logic [7:0]  exp_q [$];
  txn_t        txn_q [$];
  bit          mon_bits [$];

  int tests = 0;
  int failed = 0;
  int issued = 0;
  int done_cnt = 0;
  int rises = 0;
  int lead_cnt = 0;
  int high_cnt = 0;
  int ss_high_cnt = 0;
  int ready_mode = 0;
  bit prev_sck = 1'b0;
  bit prev_ss = 1'b1;
  bit have_gap = 1'b0;
  bit ss_low_seen = 1'b0;
  bit pend_valid = 1'b0;
  logic [7:0] pend_data = 8'h00;

  // Flash model: it shifts in the command and address on rising SCK and
  // drives the next data bit after each falling SCK edge, MSB first.
  int          f_bits = 0;
  int          f_idx;
  int          f_a;
  logic [31:0] f_sr = 32'd0;
  logic [7:0]  f_b;
  always @(posedge spi_sck or negedge spi_sck or posedge spi_ss) begin
    if (spi_ss) begin
      f_bits   = 0;
      spi_miso = 1'b0;
    end else if (spi_sck) begin
      if (f_bits < 32) f_sr = {f_sr[30:0], spi_mosi};
      f_bits++;
    end else if (f_bits >= HDR) begin
      f_idx    = f_bits - HDR;
      f_a      = (int'(f_sr[9:0]) + f_idx / 8) % 1024;
      f_b      = fmem[f_a];
      spi_miso = f_b[7 - (f_idx % 8)];
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic report_fail(input string name, input int actual, input int expected);
    tests++;
    failed++;
    $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic [23:0] a, input logic [15:0] l,
                                input bit expect_it);
    @(posedge clk); #1;
    start = 1'b1;
    addr  = a;
    len   = l;
    if (expect_it) begin
      txn_q.push_back('{a, l});
      for (int k = 0; k < int'(l); k++)
        exp_q.push_back(fmem[(int'(a[9:0]) + k) % 1024]);
      issued++;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_txn_end(input int budget);
    int n = 0;
    while ((done_cnt < issued) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < issued) report_fail("txn_timeout", done_cnt, issued);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) report_fail("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic ready_loop();
    data_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       data_ready = 1'b1;
        1:       data_ready = ($urandom_range(0, 3) != 0);
        default: data_ready = 1'b0;
      endcase
    end
  endtask

  task automatic monitor_loop();
    txn_t        t;
    logic [31:0] hdr;
    int          ones;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_bits.delete();
        rises       = 0;
        prev_sck    = 1'b0;
        prev_ss     = 1'b1;
        have_gap    = 1'b0;
        ss_high_cnt = 0;
        ss_low_seen = 1'b0;
        pend_valid  = 1'b0;
      end else begin
        if (!spi_ss && prev_ss) begin
          ss_low_seen = 1'b1;
          lead_cnt    = 1;
          if (have_gap) check_output("ss_high_gap", 32'(ss_high_cnt >= 2 * CLK_DIV), 32'd1);
        end else if (!spi_ss && !spi_sck && (rises == 0)) begin
          lead_cnt++;
        end
        if (spi_ss && !prev_ss) begin
          ss_high_cnt = 1;
          have_gap    = 1'b1;
        end else if (spi_ss) begin
          ss_high_cnt++;
        end

        if (spi_sck && !prev_sck) begin
          rises++;
          mon_bits.push_back(spi_mosi);
          if (rises == 1) check_output("first_rise_delay", 32'(lead_cnt), 32'(CLK_DIV));
          high_cnt = 1;
        end else if (spi_sck) begin
          high_cnt++;
        end
        if (!spi_sck && prev_sck) check_output("sck_high_width", 32'(high_cnt), 32'(CLK_DIV));

        if (pend_valid) begin
          check_output("data_held_valid", 32'(data_valid), 32'd1);
          check_output("data_stable", 32'(data), 32'(pend_data));
        end
        if (data_valid && data_ready) begin
          if (exp_q.size() == 0) report_fail("unexpected_byte", int'(data), -1);
          else check_output("data_byte", 32'(data), 32'(exp_q.pop_front()));
          pend_valid = 1'b0;
        end else begin
          pend_valid = data_valid;
          pend_data  = data;
        end

        if (done) begin
          done_cnt++;
          if (txn_q.size() == 0) begin
            report_fail("unexpected_done", done_cnt, issued);
          end else begin
            t = txn_q.pop_front();
            check_output("sck_rises", 32'(rises), (t.l == 16'd0) ? 32'd0 : 32'(HDR + 8 * int'(t.l)));
            check_output("ss_asserted", 32'(ss_low_seen), 32'(t.l != 16'd0));
            check_output("busy_at_done", 32'(busy), 32'd0);
            if (t.l != 16'd0) begin
              hdr  = 32'd0;
              ones = 0;
              for (int i = 0; i < 32; i++)
                hdr = {hdr[30:0], (i < mon_bits.size()) ? mon_bits[i] : 1'b0};
              for (int i = 32; i < mon_bits.size(); i++)
                if (mon_bits[i]) ones++;
              check_output("mosi_cmd_addr", hdr, {OPC, t.a});
              check_output("mosi_low_after_addr", 32'(ones), 32'd0);
            end
          end
          mon_bits.delete();
          rises       = 0;
          ss_low_seen = 1'b0;
        end
        prev_sck = spi_sck;
        prev_ss  = spi_ss;
      end
    end
  endtask

  initial begin
    int   n;
    int   r;
    int   s;
    int   dc;
    bit   p;
    logic [7:0] opc_v;
    logic [15:0] rl;

    opc_v = OPC;
    for (int i = 0; i < 1024; i++) fmem[i] = 8'($urandom);
    fmem[10'h345] = 8'hA5;
    fmem[10'h346] = 8'h5A;
    fmem[10'h347] = 8'hC3;

    rst_n = 1'b0;
    start = 1'b0;
    addr  = 24'd0;
    len   = 16'd0;
    fork
      monitor_loop();
      ready_loop();
      begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ss", 32'(spi_ss), 32'd1);
    check_output("reset_sck", 32'(spi_sck), 32'd0);
    check_output("reset_mosi", 32'(spi_mosi), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_data", 32'(data), 32'd0);
    check_output("reset_valid", 32'(data_valid), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] basic read, len=3");
    ready_mode = 0;
    apply_stimulus(24'h012345, 16'd3, 1'b1);
    check_output("start_busy", 32'(busy), 32'd1);
    check_output("start_ss", 32'(spi_ss), 32'd0);
    check_output("start_mosi_msb", 32'(spi_mosi), 32'(opc_v[7]));
    wait_txn_end(2000);
    drain(200);

    $display("[TB] single byte read, len=1");
    apply_stimulus(24'hABC347, 16'd1, 1'b1);
    wait_txn_end(2000);
    drain(200);

    $display("[TB] zero length request");
    apply_stimulus(24'h000010, 16'd0, 1'b1);
    check_output("len0_done_pulse", 32'(done), 32'd1);
    check_output("len0_ss_high", 32'(spi_ss), 32'd1);
    check_output("len0_not_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_output("len0_done_single", 32'(done), 32'd0);
    wait_txn_end(50);

    $display("[TB] consumer stall, len=2");
    ready_mode = 2;
    apply_stimulus(24'h7F0100, 16'd2, 1'b1);
    n = 0;
    while (!data_valid && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    check_output("stall_first_byte", 32'(data_valid), 32'd1);
    p = spi_sck;
    r = 0;
    s = 0;
    repeat (100) begin
      @(negedge clk);
      if (spi_sck && !p) r++;
      if (spi_ss) s++;
      p = spi_sck;
    end
    check_output("stall_no_sck_rise", 32'(r), 32'd0);
    check_output("stall_ss_low", 32'(s), 32'd0);
    ready_mode = 0;
    wait_txn_end(2000);
    drain(200);

    $display("[TB] reset during address phase");
    apply_stimulus(24'h5A5A5A, 16'd4, 1'b0);
    n = 0;
    while (!((rises >= 18) && !spi_sck) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    check_output("reached_addr_bit10", 32'(rises >= 18), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_output("abort_ss", 32'(spi_ss), 32'd1);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_valid", 32'(data_valid), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (30) @(negedge clk);
    check_output("abort_no_done", 32'(done_cnt), 32'(dc));

    $display("[TB] start while busy, then back-to-back");
    apply_stimulus(24'h012345, 16'd3, 1'b1);
    repeat (20) @(posedge clk);
    check_output("busy_before_ignored_start", 32'(busy), 32'd1);
    apply_stimulus(24'hFFFF00, 16'd5, 1'b0);
    wait_txn_end(3000);
    apply_stimulus(24'h000200, 16'd1, 1'b1);
    wait_txn_end(2000);
    drain(200);
    check_output("txn_count", 32'(done_cnt), 32'(issued));

    $display("[TB] randomized reads");
    ready_mode = 1;
    for (int i = 0; i < 12; i++) begin
      rl = 16'($urandom_range(0, 5));
      apply_stimulus(24'($urandom), rl, 1'b1);
      wait_txn_end(5000);
    end
    ready_mode = 0;
    drain(500);

    check_output("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    check_output("txns_outstanding", 32'(txn_q.size()), 32'd0);
    check_output("final_txn_count", 32'(done_cnt), 32'(issued));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
